// File: rtl/calc1_pkg.sv
// Shared types and constants for the calc1 port driver: command/response codes,
// FSM state encoding and the queued-op record.
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE    = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK      = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR     = 2'd2;
    localparam logic [RESP_W-1:0] RESP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
    } op_t;

    function automatic logic is_known_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_NOP) || (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc1_op_fifo.sv
// Small circular FIFO of queued calc1 ops; push and pop may share an edge.
module calc1_op_fifo
    import calc1_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  op_t              wdata,
    output op_t              rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    op_t              mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never presents its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/calc1_port_driver.sv
// Drives queued ops into one calc1 port as a cmd/data1 beat then a data2 beat,
// waits for the response (or a timeout) and holds the result until accepted.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [CMD_W-1:0]  op_cmd,
    input  logic [DATA_W-1:0] op_data1,
    input  logic [DATA_W-1:0] op_data2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [RESP_W-1:0] out_resp,
    input  logic [DATA_W-1:0] out_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RESP_W-1:0] res_resp,
    output logic [DATA_W-1:0] res_data,
    output logic [CMD_W-1:0]  res_cmd,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a held result stays stable until taken.

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    op_t              fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_push, fifo_pop;

    state_t            state_q, state_d;
    op_t               cur_q, cur_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [CMD_W-1:0]  req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              res_valid_q, res_valid_d;
    logic [RESP_W-1:0] res_resp_q, res_resp_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [CMD_W-1:0]  res_cmd_q, res_cmd_d;

    assign fifo_wdata = {op_cmd, op_data1, op_data2};
    assign op_ready   = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push  = op_valid && op_ready;

    calc1_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (c_clk),
        .rst_n (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        req_cmd_d   = CMD_NOP;
        req_data_d  = '0;
        res_valid_d = res_valid_q;
        res_resp_d  = res_resp_q;
        res_data_d  = res_data_q;
        res_cmd_d   = res_cmd_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_d      = fifo_rdata;
                    req_cmd_d  = fifo_rdata.cmd;
                    req_data_d = fifo_rdata.data1;
                    state_d    = ST_SEND1;
                end
            end
            ST_SEND1: begin
                req_data_d = cur_q.data2;
                state_d    = ST_SEND2;
            end
            ST_SEND2: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A response on the final counted edge still beats the timeout.
                if (out_resp != RESP_NONE) begin
                    res_valid_d = 1'b1;
                    res_resp_d  = out_resp;
                    res_data_d  = out_data;
                    res_cmd_d   = cur_q.cmd;
                    state_d     = ST_HOLD;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    res_valid_d = 1'b1;
                    res_resp_d  = RESP_TIMEOUT;
                    res_data_d  = '0;
                    res_cmd_d   = cur_q.cmd;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            cnt_q       <= '0;
            req_cmd_q   <= '0;
            req_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_resp_q  <= '0;
            res_data_q  <= '0;
            res_cmd_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            req_cmd_q   <= req_cmd_d;
            req_data_q  <= req_data_d;
            res_valid_q <= res_valid_d;
            res_resp_q  <= res_resp_d;
            res_data_q  <= res_data_d;
            res_cmd_q   <= res_cmd_d;
        end
    end

    assign req_cmd_out  = req_cmd_q;
    assign req_data_out = req_data_q;
    assign res_valid    = res_valid_q;
    assign res_resp     = res_resp_q;
    assign res_data     = res_data_q;
    assign res_cmd      = res_cmd_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: timeline reference model, directed cases and random ops.
module tb_calc1_port_driver;
  import calc1_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  // ---------------- clock / reset ----------------
  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [3:0]        op_cmd = '0;
  logic [31:0]       op_data1 = '0, op_data2 = '0;
  logic [3:0]        req_cmd_out;
  logic [31:0]       req_data_out;
  logic [1:0]        out_resp = '0;
  logic [31:0]       out_data = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [1:0]        res_resp;
  logic [31:0]       res_data;
  logic [3:0]        res_cmd;
  logic              busy;
  state_t            dbg_state;

  calc1_port_driver #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_resp(res_resp), .res_data(res_data), .res_cmd(res_cmd),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_bad = 0;
  int e = 0;            // index of the last rising edge seen by the model

  op_t sq[$];           // stimulus waiting to be offered
  op_t mq[$];           // ops the driver holds in its queue
  logic [3:0] exp_q[$]; // result cmds in the order they must come back
  logic [3:0] got_q[$]; // result cmds actually handed over

  bit   cur_v = 0;
  op_t  cur;
  int   t0 = 0;         // edge that issued the first beat of cur
  int   t_res = -1;     // edge the result was captured, -1 while waiting
  int   free_e = -1;    // edge the last result was handed over
  logic [1:0]  m_resp = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_cmd  = '0;

  // stimulus knobs
  int   vpct = 100;
  int   rr_mode = 0;    // 0: ready high, 1: random, 2: ready low
  int   rsp_dly = 0;    // response edge = SEND2 edge + rsp_dly; 0 = never
  bit   rand_dly = 0;
  bit   plan_auto = 0;
  bit   noise = 0;
  logic [1:0]  plan_resp = '0;
  logic [31:0] plan_data = '0;
  bit   saw_full = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic logic [31:0] calc_ref(input op_t o);
    case (o.cmd)
      CMD_ADD: return o.data1 + o.data2;
      CMD_SUB: return o.data1 - o.data2;
      CMD_SHL: return o.data1 << o.data2[4:0];
      CMD_SHR: return o.data1 >> o.data2[4:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    sq.delete(); mq.delete();
    cur_v = 0; t_res = -1; free_e = -1;
    m_resp = '0; m_data = '0; m_cmd = '0;
  endtask

  // Applies the rules of one rising edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit start, accept;
    op_t o;
    accept = op_valid && (mq.size() < DEPTH);
    start  = !cur_v && (mq.size() > 0) && (e > free_e);
    if (cur_v) begin
      if (t_res < 0) begin
        if (e >= t0 + 3 && e <= t0 + 2 + TO && out_resp != 2'd0) begin
          m_resp = out_resp; m_data = out_data; m_cmd = cur.cmd; t_res = e;
        end else if (e == t0 + 2 + TO) begin
          m_resp = RESP_TIMEOUT; m_data = '0; m_cmd = cur.cmd; t_res = e;
        end
      end else if (res_ready) begin
        cur_v = 0; free_e = e;
      end
    end
    if (start) begin
      cur = mq.pop_front(); cur_v = 1; t0 = e; t_res = -1;
    end
    if (accept) begin
      o.cmd = op_cmd; o.data1 = op_data1; o.data2 = op_data2;
      mq.push_back(o);
      void'(sq.pop_front());
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  xc;
    logic [31:0] xd;
    xc = '0; xd = '0;
    if (cur_v && e == t0) begin xc = cur.cmd; xd = cur.data1; end
    else if (cur_v && e == t0 + 1) xd = cur.data2;
    chk("req_cmd_out", 32'(req_cmd_out), 32'(xc));
    chk("req_data_out", req_data_out, xd);
    chk("res_valid", 32'(res_valid), 32'(cur_v && t_res >= 0));
    chk("res_resp", 32'(res_resp), 32'(m_resp));
    chk("res_data", res_data, m_data);
    chk("res_cmd", 32'(res_cmd), 32'(m_cmd));
    chk("op_ready", 32'(op_ready), 32'(mq.size() < DEPTH));
    chk("busy", 32'(busy), 32'(cur_v || mq.size() > 0));
    if (op_ready === 1'b0) saw_full = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    int en;
    en = e + 1;
    if (sq.size() > 0 && $urandom_range(0, 99) < vpct) begin
      op_valid = 1'b1; op_cmd = sq[0].cmd; op_data1 = sq[0].data1; op_data2 = sq[0].data2;
    end else begin
      op_valid = 1'b0; op_cmd = 4'($urandom); op_data1 = $urandom; op_data2 = $urandom;
    end
    case (rr_mode)
      0: res_ready = 1'b1;
      1: res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
    if (rand_dly && cur_v && e == t0) rsp_dly = $urandom_range(1, TO + 3);
    if (cur_v && t_res < 0 && rsp_dly > 0 && en == t0 + 1 + rsp_dly) begin
      out_resp = plan_auto ? 2'($urandom_range(1, 2)) : plan_resp;
      out_data = plan_auto ? calc_ref(cur) : plan_data;
    end else if (noise && $urandom_range(0, 19) == 0) begin
      out_resp = 2'($urandom_range(1, 3)); out_data = $urandom;
    end else begin
      out_resp = 2'd0; out_data = $urandom;
    end
    if (res_valid === 1'b1 && res_ready) got_q.push_back(res_cmd);
  endtask

  task automatic cycle();
    @(posedge c_clk);
    e++;
    model_edge();
    @(negedge c_clk);
    check_outputs();
    drive_inputs();
  endtask

  task automatic add_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.cmd = c; o.data1 = a; o.data2 = b;
    sq.push_back(o);
    exp_q.push_back(c);
  endtask

  task automatic drain(input int limit);
    bit idle;
    idle = 0;
    for (int i = 0; i < limit; i++) begin
      if (sq.size() == 0 && mq.size() == 0 && !cur_v) begin idle = 1; break; end
      cycle();
    end
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  task automatic cycles_until_result(input int limit);
    bit hit;
    hit = 0;
    for (int i = 0; i < limit; i++) begin
      if (cur_v && t_res >= 0) begin hit = 1; break; end
      cycle();
    end
    chk("result_seen", 32'(hit), 32'd1);
  endtask

  task automatic compare_order(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_order"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete(); exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] t3_cmds [6];
    t3_cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15};

    #1;
    check_outputs();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge c_clk);
    @(negedge c_clk);
    reset = 1'b1;
    drive_inputs();

    // ADD 1 + 0x1FFFFFFF answered OK three cycles after the second beat
    rsp_dly = 3; plan_resp = RESP_OK; plan_data = 32'h2000_0000;
    add_op(CMD_ADD, 32'h0000_0001, 32'h1FFF_FFFF);
    drain(100);
    chk("add_ok_resp", 32'(res_resp), 32'd1);
    chk("add_ok_data", res_data, 32'h2000_0000);
    chk("add_ok_cmd", 32'(res_cmd), 32'd1);

    // ADD with overflow answered ERR
    rsp_dly = 2; plan_resp = RESP_ERR; plan_data = 32'h0;
    add_op(CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    drain(100);
    chk("add_err_resp", 32'(res_resp), 32'd2);
    chk("add_err_cmd", 32'(res_cmd), 32'd1);
    compare_order("dir");

    // six back-to-back ops against a slow responder fill the queue
    rsp_dly = 8; plan_auto = 1; saw_full = 0;
    for (int i = 0; i < 6; i++) add_op(t3_cmds[i], $urandom, $urandom);
    drain(400);
    chk("burst_full_seen", 32'(saw_full), 32'd1);
    compare_order("burst");

    // silent responder: timeout, then late responses in HOLD are ignored
    rsp_dly = 0; rr_mode = 2;
    add_op(CMD_SUB, 32'h1234_5678, 32'h0000_0008);
    cycles_until_result(TO + 20);
    noise = 1;
    repeat (8) cycle();
    chk("timeout_resp", 32'(res_resp), 32'(RESP_TIMEOUT));
    chk("timeout_data", res_data, 32'h0);
    noise = 0; rr_mode = 0;
    drain(100);

    // result held 10 cycles with a second op waiting behind it
    rsp_dly = 3; rr_mode = 2;
    add_op(CMD_SHL, 32'h0000_00FF, 32'h0000_0004);
    add_op(CMD_SHR, 32'hF000_0000, 32'h0000_0010);
    cycles_until_result(40);
    noise = 1;
    repeat (10) cycle();
    noise = 0; rr_mode = 0;
    drain(100);
    compare_order("hold");

    // asynchronous reset while one op waits and two more are queued
    rsp_dly = 0;
    add_op(CMD_ADD, 32'h1, 32'h2);
    add_op(CMD_SUB, 32'h3, 32'h4);
    add_op(CMD_SHL, 32'h5, 32'h6);
    for (int i = 0; i < 20; i++) begin
      if (cur_v && e >= t0 + 3 && mq.size() == 2) break;
      cycle();
    end
    chk("rst_setup_queued", 32'(mq.size()), 32'd2);
    #2 reset = 1'b0;
    #1;
    model_reset();
    exp_q.delete(); got_q.delete();
    check_outputs();
    chk("rst_state_async", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge c_clk);
    reset = 1'b1;
    drive_inputs();
    repeat (TO + 8) cycle();
    chk("rst_no_result", 32'(got_q.size()), 32'd0);

    // random ops, random response timing, random result back-pressure
    rand_dly = 1; plan_auto = 1; noise = 1; rr_mode = 1; vpct = 50;
    for (int i = 0; i < 150; i++) add_op(4'($urandom_range(0, 15)), $urandom, $urandom);
    drain(8000);
    compare_order("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, number of queued ops; TIMEOUT, default 64, max WAIT cycles before a timeout result.
REQ-002 SHALL have port c_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports op_valid  input  1, op_ready  output  1: op-side handshake.
REQ-005 SHALL have ports op_cmd  input  4, op_data1  input  32, op_data2  input  32: command and both operands.
REQ-006 SHALL have ports req_cmd_out  output  4, req_data_out  output  32: driven into one calc1 port (reqN_cmd_in, reqN_data_in).
REQ-007 SHALL have ports out_resp  input  2, out_data  input  32: the matching calc1 port response.
REQ-008 SHALL have ports res_valid  output  1, res_ready  input  1, res_resp  output  2, res_data  output  32, res_cmd  output  4 (echo of issued cmd).
REQ-009 SHALL have port busy  output  1: high in any state other than IDLE or when FIFO is non-empty.

Function
REQ-010 SHALL queue ops in a FIFO_DEPTH-entry FIFO; push when op_valid && op_ready; op_ready = (count < FIFO_DEPTH).
REQ-011 SHALL support push and pop on the same edge when not full; count then stays unchanged.
REQ-012 SHALL implement FSM states IDLE, SEND1, SEND2, WAIT, HOLD.
REQ-013 IDLE -> SEND1 when FIFO non-empty, popping head on that edge; otherwise stay IDLE.
REQ-014 SEND1 SHALL drive registered req_cmd_out = cmd, req_data_out = op_data1 for exactly one cycle, then SEND2.
REQ-015 SEND2 SHALL drive req_cmd_out = 0, req_data_out = op_data2 for exactly one cycle, then WAIT.
REQ-016 WAIT, HOLD, IDLE SHALL drive req_cmd_out = 0, req_data_out = 0.
REQ-017 WAIT SHALL clear a cycle counter on entry; on an edge where out_resp != 0, capture out_resp/out_data into res_resp/res_data and go HOLD.
REQ-018 If counter reaches TIMEOUT with out_resp == 0, SHALL go HOLD with res_resp = 3, res_data = 0.
REQ-019 out_resp != 0 in IDLE, SEND1, SEND2 or HOLD SHALL be ignored.
REQ-020 HOLD SHALL assert res_valid with res_resp/res_data/res_cmd stable until res_valid && res_ready, then IDLE with res_valid low next cycle.
REQ-021 Minimum latency: op accepted at edge k -> SEND1 from edge k+1, SEND2 k+2, WAIT k+3.
REQ-022 Commands SHALL be forwarded unchanged, including invalid codes; validity is calc1's job.
REQ-023 Results SHALL return in acceptance order; one op outstanding at a time.

Reset
REQ-024 reset low SHALL immediately force: state IDLE, FIFO empty, req_cmd_out 0, req_data_out 0, res_valid 0, res_resp 0, res_data 0, res_cmd 0, busy 0, op_ready 1.
REQ-025 Reset mid-operation SHALL discard the in-flight op and all queued ops; no result is produced for them after release.

Structure
REQ-026 Package calc1_pkg SHALL hold command codes (NOP 0, ADD 1, SUB 2, SHL 5, SHR 6), response codes (NONE 0, OK 1, ERR 2, TIMEOUT 3), FSM state encoding, width constants.
REQ-027 FIFO SHALL be sub-module calc1_op_fifo (storage, pointers, count); FSM and timeout counter live in calc1_port_driver.

Verification
REQ-028 Push ADD 0x00000001, 0x1FFFFFFF; model returns resp 1 data 0x20000000 3 cycles after SEND2 -> ports show 1/0x00000001 then 0/0x1FFFFFFF; res_valid with resp 1, data 0x20000000, res_cmd 1.
REQ-029 Push ADD 0xFFFFFFFF, 0x00000001; model returns resp 2 -> res_resp 2 forwarded, res_cmd 1.
REQ-030 Push 6 ops on consecutive cycles, res_ready = 1, slow model -> op_ready low while count = 4; all 6 results in push order.
REQ-031 Model never responds -> res_resp 3, res_data 0 exactly TIMEOUT cycles after WAIT entry; late out_resp then ignored.
REQ-032 Hold res_ready low 10 cycles in HOLD -> res_valid/res_data stable, req_cmd_out stays 0, no SEND1 until handshake.
REQ-033 Assert reset during WAIT with 2 ops queued -> outputs zero without a clock edge; after release op_ready 1, busy 0, no res_valid.
